lu_operand_loader: RTL and testbench
====================================

Name: lu_operand_loader

Overview:
Upstream feeder for the 4-bit selectable logic unit (AND when select=1, OR when select=0).
- Receives a serial nibble stream over a valid/ready handshake.
- Assembles each 3-beat frame (operand A, operand B, select) into parallel registers.
- Presents the registers to the logic unit with an output valid/ready handshake.
- Flags framing errors and counts completed frames.

Parameters:
- WIDTH, 4, operand width in bits; also the width of the input beat.
- CNT_W, 8, width of the completed-frame counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  beat payload.
- in_valid  input  1  beat present.
- in_first  input  1  marks the first beat of a frame (operand A).
- in_ready  output  1  loader can accept a beat.
- op_a  output  WIDTH  operand A to the logic unit.
- op_b  output  WIDTH  operand B to the logic unit.
- op_sel  output  1  select to the logic unit (1=AND, 0=OR).
- out_valid  output  1  op_a, op_b and op_sel form a complete frame.
- out_ready  input  1  downstream consumes the frame.
- frame_err  output  1  one-cycle pulse on a framing violation.
- frame_cnt  output  CNT_W  number of frames consumed downstream; wraps.

Behaviour:
- Reset (async assert, sync deassert use only):
  - state=S_A.
  - op_a=0, op_b=0, op_sel=0, out_valid=0, frame_err=0, frame_cnt=0.
  - in_ready=1 from the first cycle after reset.
- Beat transfer: in_valid & in_ready sampled at a rising edge.
- in_ready: combinational; 1 in S_A, S_B and S_SEL; 0 in S_OUT.
- FSM transitions (no transition and no change without a transfer):
  - S_A:
    - in_first=1: op_a<=in_data, go to S_B.
    - in_first=0: beat dropped, frame_err pulses, stay in S_A.
  - S_B:
    - in_first=0: op_b<=in_data, go to S_SEL.
    - in_first=1: resync; op_a<=in_data, frame_err pulses, stay in S_B.
  - S_SEL:
    - in_first=0: op_sel<=in_data[0], go to S_OUT.
      - If in_data[WIDTH-1:1]!=0, frame_err pulses but the beat is still accepted.
    - in_first=1: resync; op_a<=in_data, frame_err pulses, go to S_B.
  - S_OUT:
    - out_valid=1.
    - out_ready=1: go to S_A, out_valid=0 from the next cycle, frame_cnt<=frame_cnt+1 (wraps from 2^CNT_W-1 to 0).
    - out_ready=0: hold. op_a, op_b and op_sel must not change while out_valid=1.
- out_valid: registered; rises on the cycle after the edge that accepts the select beat.
- Latency and throughput:
  - The first beat of a frame leads out_valid by 3 cycles with back-to-back beats.
  - Minimum 4 cycles per frame (3 beats + 1 hand-off cycle).
  - No overlap of the next frame with S_OUT.
- frame_err: registered; high exactly one cycle per violating beat. Consecutive violating beats give consecutive pulses.
- Operand registers change only on their capture beats. Their values are meaningful to the logic unit only while out_valid=1.
- Reset mid-frame: the partial frame is discarded, all outputs return to reset values, and the next frame must begin with in_first=1.
- Gaps: in_valid=0 cycles between beats are legal in any state and leave state unchanged.

Decomposition:
- Shared package lu_pkg contains:
  - LU_WIDTH=4.
  - SEL_AND=1'b1, SEL_OR=1'b0.
  - Enumerated FSM state type with values S_A, S_B, S_SEL, S_OUT.
- No sub-module. The block is one FSM plus a register datapath; the logic unit itself stays a separate, unchanged module instantiated by the parent.

Test Plan:
- Clean frame: beats 0101(first), 1010, 0001 with out_ready=1 -> out_valid=1 for 1 cycle with op_a=0101, op_b=1010, op_sel=1. Downstream logic unit output = 0000; frame_cnt=1.
- Backpressure: frame 1111(first), 0000, 0000 with out_ready=0 for 5 cycles, then 1 ->
  - out_valid held for 6 cycles with operands stable.
  - in_ready=0 throughout that hold.
  - Logic unit output = 1111 (OR).
  - frame_cnt increments once.
- Stray beat: beat 0011 with in_first=0 in S_A -> beat dropped, frame_err pulses 1 cycle. The following frame 1001(first), 1000, 0001 yields op_a=1001, op_b=1000, op_sel=1 and logic unit output 1000.
- Resync: 0101(first), then 1100(first), 0011, 0000 -> frame_err pulses once; output frame op_a=1100, op_b=0011, op_sel=0 (OR gives 1111).
- Select with upper bits set: select beat 0110 -> accepted with op_sel=0, frame_err pulses 1 cycle, out_valid still rises.
- Reset and wrap:
  - rst_n low after the B beat -> all outputs 0 immediately; a new full frame completes normally.
  - With CNT_W=2, 5 frames -> frame_cnt sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/lu_pkg.sv
// Shared definitions for the logic-unit operand loader.
package lu_pkg;

   localparam int LU_WIDTH = 4;

   localparam logic SEL_AND = 1'b1;
   localparam logic SEL_OR  = 1'b0;

   typedef enum logic [1:0] {
      S_A   = 2'd0,
      S_B   = 2'd1,
      S_SEL = 2'd2,
      S_OUT = 2'd3
   } lu_state_t;

endpackage

// File: rtl/lu_operand_loader.sv
// Assembles a 3-beat nibble frame (A, B, select) into parallel operands for the
// selectable logic unit, with framing-error detection and a consumed-frame counter.
module lu_operand_loader
   import lu_pkg::*;
#(
   parameter int WIDTH = LU_WIDTH,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             in_first,
   output logic             in_ready,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic             op_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             frame_err,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [1:0]       fsm_state
);

   // Handshakes: a beat moves when in_valid & in_ready at a rising edge, a frame
   // moves when out_valid & out_ready; valid never waits on ready combinationally.
   lu_state_t state, next_state;
   logic      xfer;
   logic      load_a, load_b, load_sel, consume, err_next;

   assign in_ready  = (state != S_OUT);
   assign xfer      = in_valid & in_ready;
   assign out_valid = (state == S_OUT);
   assign fsm_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_A;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      load_a     = 1'b0;
      load_b     = 1'b0;
      load_sel   = 1'b0;
      consume    = 1'b0;
      err_next   = 1'b0;
      case (state)
         S_A: begin
            if (xfer) begin
               if (in_first) begin
                  load_a     = 1'b1;
                  next_state = S_B;
               end else begin
                  err_next   = 1'b1;
               end
            end
         end
         S_B: begin
            if (xfer) begin
               if (in_first) begin
                  load_a     = 1'b1;
                  err_next   = 1'b1;
               end else begin
                  load_b     = 1'b1;
                  next_state = S_SEL;
               end
            end
         end
         S_SEL: begin
            if (xfer) begin
               if (in_first) begin
                  load_a     = 1'b1;
                  err_next   = 1'b1;
                  next_state = S_B;
               end else begin
                  // Nonzero padding above the select bit is flagged but the beat still lands.
                  load_sel   = 1'b1;
                  err_next   = |in_data[WIDTH-1:1];
                  next_state = S_OUT;
               end
            end
         end
         S_OUT: begin
            if (out_ready) begin
               consume    = 1'b1;
               next_state = S_A;
            end
         end
         default: next_state = S_A;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a      <= '0;
         op_b      <= '0;
         op_sel    <= 1'b0;
         frame_err <= 1'b0;
         frame_cnt <= '0;
      end else begin
         frame_err <= err_next;
         if (load_a)   op_a      <= in_data;
         if (load_b)   op_b      <= in_data;
         if (load_sel) op_sel    <= in_data[0];
         if (consume)  frame_cnt <= frame_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_lu_operand_loader.sv
// Directed bench for lu_operand_loader; a second instance with a 2-bit counter
// shares the stimulus to exercise counter wrap.
module tb_lu_operand_loader;
   import lu_pkg::*;

   logic       clk;
   logic       rst_n;
   logic [3:0] in_data;
   logic       in_valid;
   logic       in_first;
   logic       out_ready;

   logic       in_ready, op_sel, out_valid, frame_err;
   logic [3:0] op_a, op_b;
   logic [7:0] frame_cnt;
   logic [1:0] fsm_state;

   logic       in_ready2, op_sel2, out_valid2, frame_err2;
   logic [3:0] op_a2, op_b2;
   logic [1:0] frame_cnt2;
   logic [1:0] fsm_state2;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         exp_cnt = 0;
   logic [8:0] exp_q[$];

   lu_operand_loader #(.WIDTH(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_first(in_first), .in_ready(in_ready), .op_a(op_a), .op_b(op_b),
      .op_sel(op_sel), .out_valid(out_valid), .out_ready(out_ready),
      .frame_err(frame_err), .frame_cnt(frame_cnt), .fsm_state(fsm_state)
   );

   lu_operand_loader #(.WIDTH(4), .CNT_W(2)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_first(in_first), .in_ready(in_ready2), .op_a(op_a2), .op_b(op_b2),
      .op_sel(op_sel2), .out_valid(out_valid2), .out_ready(out_ready),
      .frame_err(frame_err2), .frame_cnt(frame_cnt2), .fsm_state(fsm_state2)
   );

   // Clock and watchdog.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] lu_out(input logic [3:0] a, input logic [3:0] b, input logic s);
      return (s == SEL_AND) ? (a & b) : (a | b);
   endfunction

   // Drivers: called at posedge+1, return at posedge+1 after the beat transfers.
   task automatic beat(input logic [3:0] d, input logic first);
      int k;
      in_data  = d;
      in_first = first;
      in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      if (k == 20) check("ready_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_first = 1'b0;
   endtask

   task automatic run_frame(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
      beat(a, 1'b1);
      beat(b, 1'b0);
      exp_q.push_back({a, b, s[0]});
      beat(s, 1'b0);
   endtask

   // Scoreboard: every consumed frame must match the oldest expected frame.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) check("sb_unexpected", 1, 0);
         else check("sb_frame", {23'd0, op_a, op_b, op_sel}, {23'd0, exp_q.pop_front()});
      end
   end

   logic [1:0] wrap_seq [5];

   initial begin
      wrap_seq  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_first  = 1'b0;
      in_data   = 4'h0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_ops", {op_a, op_b, op_sel}, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_state", fsm_state, S_A);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", in_ready, 1);

      // Clean frame, AND of 0101 and 1010.
      run_frame(4'b0101, 4'b1010, 4'b0001);
      check("clean_valid", out_valid, 1);
      check("clean_in_ready", in_ready, 0);
      check("clean_err", frame_err, 0);
      check("clean_ops", {op_a, op_b, op_sel}, 9'b0101_1010_1);
      check("clean_lu", lu_out(op_a, op_b, op_sel), 4'b0000);
      @(posedge clk); #1;
      exp_cnt = 1;
      check("clean_valid_drop", out_valid, 0);
      check("clean_cnt", frame_cnt, exp_cnt);

      // Backpressure: six cycles of hold, a beat offered meanwhile must be ignored.
      out_ready = 1'b0;
      run_frame(4'b1111, 4'b0000, 4'b0000);
      for (int i = 0; i < 6; i++) begin
         check("bp_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
         check("bp_ops", {op_a, op_b, op_sel}, 9'b1111_0000_0);
         check("bp_lu", lu_out(op_a, op_b, op_sel), 4'b1111);
         check("bp_cnt", frame_cnt, 1);
         if (i == 0) begin
            in_data = 4'b1010; in_first = 1'b1; in_valid = 1'b1;
         end
         if (i == 5) out_ready = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; in_first = 1'b0;
      exp_cnt = 2;
      check("bp_valid_drop", out_valid, 0);
      check("bp_cnt_after", frame_cnt, exp_cnt);
      check("bp_op_a_kept", op_a, 4'b1111);

      // Stray beat in S_A, then a good frame.
      beat(4'b0011, 1'b0);
      check("stray_err", frame_err, 1);
      check("stray_state", fsm_state, S_A);
      check("stray_op_a", op_a, 4'b1111);
      @(posedge clk); #1;
      check("stray_err_pulse", frame_err, 0);
      run_frame(4'b1001, 4'b1000, 4'b0001);
      check("stray_ops", {op_a, op_b, op_sel}, 9'b1001_1000_1);
      check("stray_lu", lu_out(op_a, op_b, op_sel), 4'b1000);
      @(posedge clk); #1;
      exp_cnt = 3;
      check("stray_cnt", frame_cnt, exp_cnt);

      // Resync: a second first-beat restarts the frame.
      beat(4'b0101, 1'b1);
      beat(4'b1100, 1'b1);
      check("resync_err", frame_err, 1);
      check("resync_op_a", op_a, 4'b1100);
      check("resync_state", fsm_state, S_B);
      beat(4'b0011, 1'b0);
      check("resync_err_pulse", frame_err, 0);
      exp_q.push_back(9'b1100_0011_0);
      beat(4'b0000, 1'b0);
      check("resync_valid", out_valid, 1);
      check("resync_ops", {op_a, op_b, op_sel}, 9'b1100_0011_0);
      check("resync_lu", lu_out(op_a, op_b, op_sel), 4'b1111);
      @(posedge clk); #1;
      exp_cnt = 4;
      check("resync_cnt", frame_cnt, exp_cnt);

      // Select beat with upper bits set.
      run_frame(4'b0011, 4'b0101, 4'b0110);
      check("selhi_err", frame_err, 1);
      check("selhi_valid", out_valid, 1);
      check("selhi_sel", op_sel, 0);
      check("selhi_lu", lu_out(op_a, op_b, op_sel), 4'b0111);
      @(posedge clk); #1;
      exp_cnt = 5;
      check("selhi_err_pulse", frame_err, 0);
      check("selhi_cnt", frame_cnt, exp_cnt);
      check("selhi_cnt_wrap", frame_cnt2, 2'd1);

      // Reset after the B beat.
      beat(4'b0110, 1'b1);
      beat(4'b1001, 1'b0);
      rst_n = 1'b0;
      #1;
      check("midrst_ops", {op_a, op_b, op_sel}, 0);
      check("midrst_valid_err", {out_valid, frame_err}, 0);
      check("midrst_cnt", frame_cnt, 0);
      check("midrst_state", fsm_state, S_A);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      exp_cnt = 0;
      beat(4'b0111, 1'b0);
      check("midrst_need_first", frame_err, 1);
      check("midrst_need_first_state", fsm_state, S_A);

      // Five frames: 8-bit counter 1..5, 2-bit counter 1,2,3,0,1.
      for (int f = 1; f <= 5; f++) begin
         logic [3:0] a, b;
         logic       s;
         a = 4'(f);
         b = ~4'(f);
         s = f[0];
         run_frame(a, b, {3'b000, s});
         check("wrap_ops", {op_a, op_b, op_sel}, {a, b, s});
         check("wrap_lu", lu_out(op_a, op_b, op_sel), s ? 4'b0000 : 4'b1111);
         check("wrap_dut2", {out_valid2, in_ready2, frame_err2, op_a2, op_b2, op_sel2, fsm_state2},
               {1'b1, 1'b0, 1'b0, a, b, s, S_OUT});
         @(posedge clk); #1;
         exp_cnt++;
         check("wrap_cnt8", frame_cnt, exp_cnt);
         check("wrap_cnt2", frame_cnt2, wrap_seq[f-1]);
      end

      check("sb_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
